// File: rtl/time_pkg.sv
// Shared widths, limits and state encodings for the wall-clock time setter.
// It also holds the wrap-around increment helpers used by the time registers.
package time_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } press_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_TICK = 2'd1,
        GNT_MIN  = 2'd2,
        GNT_HOUR = 2'd3
    } grant_t;

    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max_v);
        if (v == max_v) begin
            return 6'd0;
        end else begin
            return v + 6'd1;
        end
    endfunction

    function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] max_v);
        if (v == max_v) begin
            return 5'd0;
        end else begin
            return v + 5'd1;
        end
    endfunction

endpackage

// File: rtl/time_set_sched_if.sv
// Button pins in, wall-clock time and status out.
// The slave side belongs to time_set_sched; the master side belongs to the board or bench.
interface time_set_sched_if;
    import time_pkg::*;

    logic              hour_button;
    logic              minute_button;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
    logic              sec_tick;
    logic              time_upd;
    logic [1:0]        btn_state;

    modport master (
        output hour_button, minute_button,
        input  hours, minutes, seconds, sec_tick, time_upd, btn_state
    );

    modport slave (
        input  hour_button, minute_button,
        output hours, minutes, seconds, sec_tick, time_upd, btn_state
    );

endinterface

// File: rtl/button_press.sv
// One button: a 2-flop synchronizer, a debouncer and a press/auto-repeat FSM.
// inc_o is combinational, so the edge that raises the debounced level also registers the request.
module button_press
    import time_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic inc_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TM_W-1:0] DELAY_LOAD = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] RATE_LOAD  = TM_W'(REPEAT_RATE - 1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            rise_s;
    press_state_t    state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;

    // Synchronizer, debouncer, FSM state and repeat timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            state_q  <= IDLE;
            timer_q  <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
        end
    end

    // Debounce: the level flips after DEBOUNCE_CYC consecutive disagreeing samples
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    assign rise_s = level_d & ~level_q;

    // Next-state logic of the press FSM, driven by the post-edge debounced level
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD, REPEAT: begin
                if (!level_d) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = REPEAT;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: increment request and repeat timer load/decrement
    always_comb begin
        inc_o   = 1'b0;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    inc_o   = 1'b1;
                    timer_d = DELAY_LOAD;
                end else begin
                    timer_d = timer_q;
                end
            end
            HOLD, REPEAT: begin
                if (!level_d) begin
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    inc_o   = 1'b1;
                    timer_d = RATE_LOAD;
                end else begin
                    timer_d = timer_q - TM_W'(1);
                end
            end
            default: begin
                inc_o   = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    assign level_o = level_q;

endmodule

// File: rtl/time_set_sched.sv
// Owns the hh:mm:ss register and grants one write per cycle to the seconds tick,
// the minute button or the hour button, in that fixed priority order.
module time_set_sched
    import time_pkg::*;
#(
    parameter int TICK_DIV     = 25000000,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic              clk,
    input  logic              rst_n,
    time_set_sched_if.slave   bus
);

    localparam int              PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic              min_lvl_s, min_inc_s, hour_lvl_s, hour_inc_s;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic              tick_s;
    grant_t            grant_s;
    logic              min_pend_q, min_pend_d, hour_pend_q, hour_pend_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [SEC_W-1:0]  seconds_q, seconds_d;
    logic              time_upd_q;

    button_press #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_min_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.minute_button),
        .level_o (min_lvl_s),
        .inc_o   (min_inc_s)
    );

    button_press #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_hour_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.hour_button),
        .level_o (hour_lvl_s),
        .inc_o   (hour_inc_s)
    );

    assign tick_s = (presc_q == PS_LAST);

    // Fixed-priority grant: tick, then minute pending, then hour pending
    always_comb begin
        grant_s = GNT_NONE;
        if (tick_s) begin
            grant_s = GNT_TICK;
        end else if (min_pend_q) begin
            grant_s = GNT_MIN;
        end else if (hour_pend_q) begin
            grant_s = GNT_HOUR;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Next time value, prescaler and pending flags for the granted writer
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        case (grant_s)
            GNT_TICK: begin
                seconds_d = inc_wrap6(seconds_q, SEC_MAX);
                if (seconds_q == SEC_MAX) begin
                    minutes_d = inc_wrap6(minutes_q, MIN_MAX);
                    if (minutes_q == MIN_MAX) begin
                        hours_d = inc_wrap5(hours_q, HOUR_MAX);
                    end else begin
                        hours_d = hours_q;
                    end
                end else begin
                    minutes_d = minutes_q;
                end
            end
            GNT_MIN: begin
                minutes_d = inc_wrap6(minutes_q, MIN_MAX);
                seconds_d = '0;
            end
            GNT_HOUR: hours_d = inc_wrap5(hours_q, HOUR_MAX);
            default: begin
                hours_d   = hours_q;
                minutes_d = minutes_q;
                seconds_d = seconds_q;
            end
        endcase

        // A minute set restarts the second so the new minute starts cleanly
        if (tick_s || (grant_s == GNT_MIN)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end

        min_pend_d  = min_inc_s  | (min_pend_q  & (grant_s != GNT_MIN));
        hour_pend_d = hour_inc_s | (hour_pend_q & (grant_s != GNT_HOUR));
    end

    // Time, prescaler, pending and update-strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            min_pend_q  <= 1'b0;
            hour_pend_q <= 1'b0;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            time_upd_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            min_pend_q  <= min_pend_d;
            hour_pend_q <= hour_pend_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            time_upd_q  <= (grant_s != GNT_NONE);
        end
    end

    assign bus.hours     = hours_q;
    assign bus.minutes   = minutes_q;
    assign bus.seconds   = seconds_q;
    assign bus.sec_tick  = tick_s;
    assign bus.time_upd  = time_upd_q;
    assign bus.btn_state = {hour_lvl_s, min_lvl_s};

endmodule
